pll_loop_filter: RTL and testbench

Digital PI loop filter for the external PLL control path. It sits between the AD4008 ADC readout stage and the DAC8411 write stage. It takes each new ADC sample, computes the phase-detector error against a programmable setpoint, and runs a saturating proportional-integral update with anti-windup. The result is a registered 16-bit DAC code with a one-cycle valid strobe.

---
 rtl/pll_ext_pkg.sv | 19 +
 rtl/pll_pi_integrator.sv | 24 ++
 rtl/pll_loop_filter.sv | 76 +++++++
 tb/tb_pll_loop_filter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/pll_ext_pkg.sv
// pll_ext_pkg: shared FSM states, midscale helper and saturating add for the PLL loop filter
package pll_ext_pkg;
  typedef enum logic [2:0] {IDLE, ERR, PROD, SUM, OUT} state_t;
  localparam int ACC_MAX = 64;
  function automatic logic [31:0] mid_of(input int w);
    return 32'd1 << (w - 1);
  endfunction
  function automatic logic signed [ACC_MAX-1:0] sat_add(
    input logic signed [ACC_MAX-1:0] a,
    input logic signed [ACC_MAX-1:0] b,
    input int w = 32
  );
    logic signed [ACC_MAX:0] s, hi, lo;
    s = {a[ACC_MAX-1], a} + {b[ACC_MAX-1], b};
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -hi;
    return ACC_MAX'(s > hi ? hi : s < lo ? lo : s);
  endfunction
endpackage

// File: rtl/pll_pi_integrator.sv
// pll_pi_integrator: saturating integrator with conditional-integration anti-windup
module pll_pi_integrator import pll_ext_pkg::*; #(
  parameter int ACC_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        aresetn,
  input  logic signed [ACC_WIDTH-1:0] i,
  input  logic                        hold,
  input  logic [1:0]                  clamp_dir,
  input  logic                        enable,
  input  logic                        commit,
  output logic signed [ACC_WIDTH-1:0] integ_cand
);
  logic signed [ACC_WIDTH-1:0] integ;
  logic wind;
  always_comb begin
    integ_cand = ACC_WIDTH'(sat_add(ACC_MAX'(integ), ACC_MAX'(i), ACC_WIDTH));
    wind = (clamp_dir[1] && i > 0) || (clamp_dir[0] && i < 0);
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) integ <= '0;
    else if (commit && (!enable || !(hold || wind))) integ <= enable ? integ_cand : '0;
  end
endmodule

// File: rtl/pll_loop_filter.sv
// pll_loop_filter: multi-cycle PI loop filter turning ADC samples into a clamped DAC code
module pll_loop_filter import pll_ext_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 8,
  parameter int GAIN_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic                  hold,
  input  logic                  sample_valid,
  input  logic [DATA_WIDTH-1:0] sample,
  input  logic [DATA_WIDTH-1:0] setpoint,
  input  logic [GAIN_WIDTH-1:0] kp,
  input  logic [GAIN_WIDTH-1:0] ki,
  output logic [DATA_WIDTH-1:0] dac_code,
  output logic                  dac_valid,
  output logic                  busy,
  output logic                  sat_flag,
  output logic                  overrun
);
  localparam int SW = ACC_WIDTH + 1;
  localparam logic [DATA_WIDTH-1:0] MID = DATA_WIDTH'(mid_of(DATA_WIDTH));
  localparam logic signed [SW-1:0] CODE_MAX = SW'((64'd1 << DATA_WIDTH) - 64'd1);
  state_t state, next;
  logic [DATA_WIDTH-1:0] smp_q, set_q, u_c, u_q;
  logic [GAIN_WIDTH-1:0] kp_q, ki_q;
  logic en_q, hold_q, sat_hi, sat_lo;
  logic [1:0] clamp_q;
  logic signed [DATA_WIDTH:0] err, err_q;
  logic signed [ACC_WIDTH-1:0] p_next, i_next, p_q, i_q, integ_cand;
  logic signed [SW-1:0] s, u;
  always_comb begin
    next = state == IDLE ? (sample_valid ? ERR : IDLE) : state == OUT ? IDLE : state_t'(state + 3'd1);
    err = $signed({1'b0, set_q}) - $signed({1'b0, smp_q});
    p_next = ACC_WIDTH'(err_q) * ACC_WIDTH'($signed({1'b0, kp_q}));
    i_next = ACC_WIDTH'(err_q) * ACC_WIDTH'($signed({1'b0, ki_q}));
    s = SW'(p_q) + SW'(integ_cand);
    u = (s >>> FRAC_BITS) + $signed(SW'(MID));
    sat_hi = u > CODE_MAX;
    sat_lo = u[SW-1];
    u_c = sat_hi ? '1 : sat_lo ? '0 : u[DATA_WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else state <= next;
  end
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      {smp_q, set_q, kp_q, ki_q, en_q, hold_q} <= '0;
      {err_q, p_q, i_q, u_q, clamp_q} <= '0;
      dac_code <= MID;
      {dac_valid, sat_flag, overrun} <= '0;
    end else begin
      dac_valid <= 1'b0;
      if (sample_valid && state != IDLE) overrun <= 1'b1;
      if (sample_valid && state == IDLE) {smp_q, set_q, kp_q, ki_q, en_q, hold_q} <= {sample, setpoint, kp, ki, enable, hold};
      if (state == ERR) err_q <= err;
      if (state == PROD) {p_q, i_q} <= {p_next, i_next};
      if (state == SUM) {u_q, clamp_q} <= {u_c, sat_hi, sat_lo};
      if (state == OUT) {dac_valid, dac_code, sat_flag} <= {1'b1, en_q ? u_q : MID, en_q && |clamp_q};
    end
  end
  assign busy = state != IDLE || dac_valid;
  pll_pi_integrator #(.ACC_WIDTH(ACC_WIDTH)) u_integ (
    .clk(clk),
    .aresetn(aresetn),
    .i(i_q),
    .hold(hold_q),
    .clamp_dir(clamp_q),
    .enable(en_q),
    .commit(state == OUT),
    .integ_cand(integ_cand)
  );
endmodule

// File: tb/tb_pll_loop_filter.sv
// tb_pll_loop_filter: directed scoreboard bench for the PI loop filter
module tb_pll_loop_filter;
  logic clk = 0, aresetn = 0, enable = 1, hold = 0, sample_valid = 0;
  logic [15:0] sample = '0, setpoint = '0;
  logic [7:0] kp = '0, ki = '0;
  logic [15:0] dac_code;
  logic dac_valid, busy, sat_flag, overrun;
  int tests = 0, fails = 0;
  logic [16:0] exp_q[$];
  logic [16:0] e;
  logic [15:0] prev_code = 16'h8000;
  logic mon_on = 0;
  always #5 clk = ~clk;
  pll_loop_filter dut (
    .clk(clk),
    .aresetn(aresetn),
    .enable(enable),
    .hold(hold),
    .sample_valid(sample_valid),
    .sample(sample),
    .setpoint(setpoint),
    .kp(kp),
    .ki(ki),
    .dac_code(dac_code),
    .dac_valid(dac_valid),
    .busy(busy),
    .sat_flag(sat_flag),
    .overrun(overrun)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask
  always @(negedge clk) begin
    if (dac_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_dac_valid: got code %0h want no output", dac_code);
      end else begin
        e = exp_q.pop_front();
        check("dac_code", 32'(dac_code), 32'(e[15:0]));
        check("sat_flag", 32'(sat_flag), 32'(e[16]));
      end
    end else if (mon_on) check("code_hold", 32'(dac_code), 32'(prev_code));
    prev_code = dac_code;
  end
  task automatic pulse(input logic [15:0] smp, input logic [15:0] setp, input logic [7:0] p,
                       input logic [7:0] i, input logic en, input logic h);
    @(negedge clk);
    sample = smp; setpoint = setp; kp = p; ki = i; enable = en; hold = h; sample_valid = 1;
    @(negedge clk);
    sample_valid = 0;
    sample = 16'($urandom); setpoint = 16'($urandom);
    kp = 8'($urandom); ki = 8'($urandom);
    enable = 1'($urandom); hold = 1'($urandom);
  endtask
  task automatic wait_valid(input int lat);
    int n = 0;
    while (!dac_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(lat));
  endtask
  task automatic run(input logic [15:0] smp, input logic [15:0] setp, input logic [7:0] p,
                     input logic [7:0] i, input logic en, input logic h,
                     input logic [15:0] code, input logic s);
    exp_q.push_back({s, code});
    pulse(smp, setp, p, i, en, h);
    check("busy", 32'(busy), 32'd1);
    wait_valid(4);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    aresetn = 1;
    @(negedge clk);
    check("rst_code", 32'(dac_code), 32'h8000);
    check("rst_valid", 32'(dac_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sat", 32'(sat_flag), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    mon_on = 1;
    run(16'h4000, 16'h4100, 8'd16, 8'd0, 1, 0, 16'h8010, 0);
    for (int k = 1; k <= 3; k++) begin
      run(16'h4000, 16'h4100, 8'd0, 8'd1, 1, 0, 16'h8000 + 16'(k), 0);
      repeat (5) @(negedge clk);
    end
    run(16'h4000, 16'h4100, 8'd0, 8'd1, 0, 0, 16'h8000, 0);
    repeat (2) run(16'h4000, 16'h4100, 8'd0, 8'd1, 1, 1, 16'h8001, 0);
    repeat (3) run(16'h0000, 16'hFFFF, 8'd255, 8'd1, 1, 0, 16'hFFFF, 1);
    repeat (2) run(16'hFFFF, 16'h0000, 8'd255, 8'd1, 1, 0, 16'h0000, 1);
    run(16'h0100, 16'h0000, 8'd255, 8'd1, 1, 0, 16'h7F00, 0);
    run(16'h0000, 16'h0000, 8'd0, 8'd0, 0, 0, 16'h8000, 0);
    check("overrun_clear", 32'(overrun), 32'd0);
    exp_q.push_back({1'b0, 16'h8010});
    pulse(16'h4000, 16'h4100, 8'd16, 8'd0, 1, 0);
    pulse(16'h1234, 16'h4321, 8'd99, 8'd7, 1, 0);
    wait_valid(2);
    repeat (10) @(negedge clk);
    check("overrun_set", 32'(overrun), 32'd1);
    exp_q.push_back({1'b0, 16'h8010});
    pulse(16'h4000, 16'h4100, 8'd16, 8'd0, 1, 0);
    repeat (3) @(negedge clk);
    sample_valid = 1;
    @(negedge clk);
    sample_valid = 0;
    check("out_cycle_valid", 32'(dac_valid), 32'd1);
    repeat (10) @(negedge clk);
    run(16'h4000, 16'h4100, 8'd0, 8'd1, 1, 0, 16'h8001, 0);
    run(16'h4000, 16'h4100, 8'd0, 8'd1, 1, 0, 16'h8002, 0);
    run(16'h0000, 16'hFFFF, 8'd255, 8'd1, 0, 0, 16'h8000, 0);
    run(16'h4000, 16'h4100, 8'd0, 8'd1, 1, 0, 16'h8001, 0);
    check("overrun_sticky", 32'(overrun), 32'd1);
    pulse(16'h4000, 16'h4100, 8'd0, 8'd1, 1, 0);
    @(negedge clk);
    mon_on = 0;
    aresetn = 0;
    #1;
    check("midrst_code", 32'(dac_code), 32'h8000);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(dac_valid), 32'd0);
    check("midrst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    aresetn = 1;
    repeat (10) @(negedge clk);
    check("postrst_code", 32'(dac_code), 32'h8000);
    mon_on = 1;
    run(16'h4000, 16'h4100, 8'd0, 8'd1, 1, 0, 16'h8001, 0);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
